apple2_ram_arbiter: RTL and testbench

Shares the single 18-bit main/aux RAM port between the Apple II core and one secondary host requester, such as an image loader or debugger. The host gets one access per 14-cycle CPU frame, in a fixed slot the core never uses. Optionally, the block also sequences a full-RAM clear after reset while holding the CPU. It sits between the core's RAM outputs and the top-level `ram_*` pins.

---
 rtl/apple2_ram_pkg.sv | 24 ++
 rtl/apple2_slot_counter.sv | 29 ++
 rtl/apple2_ram_arbiter.sv | 137 +++++++++++++
 tb/tb_apple2_ram_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple2_ram_pkg.sv
// Shared constants and state encoding for the Apple II RAM arbiter.
// The boot clear state is only reachable when APPLE2_RAM_CLEAR_EN is defined.
package apple2_ram_pkg;

    localparam int SLOTS  = 14;
    localparam int RAM_AW = 18;

    // Byte lanes of the 16-bit RAM read bus
    localparam int LANE_MAIN_LSB = 0;
    localparam int LANE_AUX_LSB  = 8;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 3'd0;
    localparam arb_state_t ST_ARMED  = 3'd1;
    localparam arb_state_t ST_ACCESS = 3'd2;
    localparam arb_state_t ST_DONE   = 3'd3;
    localparam arb_state_t ST_CLEAR  = 3'd4;

    function automatic logic [7:0] lane_sel(input logic [15:0] d, input logic aux);
        return aux ? d[LANE_AUX_LSB +: 8] : d[LANE_MAIN_LSB +: 8];
    endfunction

endpackage

// File: rtl/apple2_slot_counter.sv
// Free-running 0..SLOTS-1 frame slot counter, realigned to 0 on the cycle
// after a PHASE_ZERO rising edge.
module apple2_slot_counter
    import apple2_ram_pkg::*;
(
    input  logic       CLK_14M,
    input  logic       reset_n,
    input  logic       PHASE_ZERO,
    output logic [3:0] slot
);

    logic pz_q;

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            pz_q <= 1'b0;
            slot <= 4'd0;
        end else begin
            pz_q <= PHASE_ZERO;
            if (PHASE_ZERO && !pz_q)
                slot <= 4'd0;
            else if (slot == 4'(SLOTS - 1))
                slot <= 4'd0;
            else
                slot <= slot + 4'd1;
        end
    end

endmodule

// File: rtl/apple2_ram_arbiter.sv
// Muxes the shared main/aux RAM port between the Apple II core and one host
// requester (one fixed slot per frame). APPLE2_RAM_CLEAR_EN adds a boot clear.
module apple2_ram_arbiter
    import apple2_ram_pkg::*;
#(
    parameter int                HOST_SLOT = 13,
    parameter logic [RAM_AW-1:0] CLEAR_TOP = 18'h3FFFF
) (
    input  logic              CLK_14M,
    input  logic              reset_n,
    input  logic              PHASE_ZERO,
    input  logic [RAM_AW-1:0] core_addr,
    input  logic              core_we,
    input  logic [7:0]        core_di,
    input  logic              core_aux,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [RAM_AW-1:0] host_addr,
    input  logic              host_aux,
    input  logic [7:0]        host_di,
    output logic              host_ack,
    output logic [7:0]        host_do,
    input  logic [15:0]       ram_do,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_di,
    output logic              ram_aux,
    output logic              core_hold,
    output logic              clear_busy
);

    logic [3:0]        slot;
    arb_state_t        state;
    logic              lat_we;
    logic              lat_aux;
    logic [RAM_AW-1:0] lat_addr;
    logic [7:0]        lat_di;

    apple2_slot_counter u_slot (
        .CLK_14M    (CLK_14M),
        .reset_n    (reset_n),
        .PHASE_ZERO (PHASE_ZERO),
        .slot       (slot)
    );

`ifdef APPLE2_RAM_CLEAR_EN
    localparam arb_state_t RESET_STATE = ST_CLEAR;

    logic [RAM_AW-1:0] clr_addr;
    logic              clr_aux;
    logic              clr_last;

    // Main pass first, then aux; the last address of the aux pass ends the clear
    assign clr_last = (clr_addr == CLEAR_TOP);

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr <= '0;
            clr_aux  <= 1'b0;
        end else if (state == ST_CLEAR) begin
            if (clr_last) begin
                clr_addr <= '0;
                clr_aux  <= 1'b1;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    assign core_hold  = (state == ST_CLEAR);
    assign clear_busy = (state == ST_CLEAR);
`else
    localparam arb_state_t RESET_STATE = ST_IDLE;

    assign core_hold  = 1'b0;
    assign clear_busy = 1'b0;
`endif

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RESET_STATE;
            lat_we   <= 1'b0;
            lat_aux  <= 1'b0;
            lat_addr <= '0;
            lat_di   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_req) begin
                        lat_we   <= host_we;
                        lat_aux  <= host_aux;
                        lat_addr <= host_addr;
                        lat_di   <= host_di;
                        state    <= ST_ARMED;
                    end
                end
                // A late host_req drop does not cancel the latched request
                ST_ARMED:  if (slot == 4'(HOST_SLOT)) state <= ST_ACCESS;
                ST_ACCESS: state <= ST_DONE;
                ST_DONE:   state <= ST_IDLE;
`ifdef APPLE2_RAM_CLEAR_EN
                ST_CLEAR:  if (clr_last && clr_aux) state <= ST_IDLE;
`endif
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_addr = core_addr;
        ram_we   = core_we;
        ram_di   = core_di;
        ram_aux  = core_aux;
        if (state == ST_ACCESS) begin
            ram_addr = lat_addr;
            ram_we   = lat_we;
            ram_di   = lat_di;
            ram_aux  = lat_aux;
        end
`ifdef APPLE2_RAM_CLEAR_EN
        else if (state == ST_CLEAR) begin
            ram_addr = clr_addr;
            ram_we   = 1'b1;
            ram_di   = 8'h00;
            ram_aux  = clr_aux;
        end
`endif
        // No stray writes while the system is held in reset
        if (!reset_n)
            ram_we = 1'b0;
    end

    // ram_do already carries the byte addressed during ACCESS
    assign host_ack = (state == ST_DONE);
    assign host_do  = host_ack ? lane_sel(ram_do, lat_aux) : 8'h00;

endmodule

// File: tb/tb_apple2_ram_arbiter.sv
// Self-checking bench for apple2_ram_arbiter: directed cases plus random
// traffic against a slot/queue reference model.
module tb_apple2_ram_arbiter;

    localparam int          HS    = 13;
    localparam logic [17:0] CT    = 18'h0000F;
    localparam int          CLR_N = 2 * (int'(CT) + 1);
`ifdef APPLE2_RAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        CLK_14M = 1'b0;
    logic        reset_n, PHASE_ZERO;
    logic [17:0] core_addr, host_addr, ram_addr;
    logic        core_we, core_aux, host_req, host_we, host_aux;
    logic [7:0]  core_di, host_di, host_do, ram_di;
    logic [15:0] ram_do;
    logic        host_ack, ram_we, ram_aux, core_hold, clear_busy;

    always #5 CLK_14M = ~CLK_14M;

    apple2_ram_arbiter #(.HOST_SLOT(HS), .CLEAR_TOP(CT)) dut (
        .CLK_14M(CLK_14M), .reset_n(reset_n), .PHASE_ZERO(PHASE_ZERO),
        .core_addr(core_addr), .core_we(core_we), .core_di(core_di), .core_aux(core_aux),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_aux(host_aux),
        .host_di(host_di), .host_ack(host_ack), .host_do(host_do), .ram_do(ram_do),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_aux(ram_aux),
        .core_hold(core_hold), .clear_busy(clear_busy)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    bit pz_auto = 1'b1;

    // Reference model: outstanding request waits for the host slot, is
    // serviced in the following cycle and acked one cycle after that.
    int          m_slot, m_acc, m_clr_k;
    bit          m_pz, m_armed, m_clr_on;
    logic        m_we, m_aux;
    logic [17:0] m_addr;
    logic [7:0]  m_di;

    logic        obs_ack, obs_we, obs_aux, obs_busy;
    logic [7:0]  obs_do, obs_di;
    logic [17:0] obs_addr;
    int          obs_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_pz = 0; m_armed = 0; m_acc = -100;
        m_clr_k = 0; m_clr_on = CLR_EN;
    endtask

    function automatic bit model_idle();
        return reset_n && !m_armed && !m_clr_on && cyc != m_acc && cyc != m_acc + 1;
    endfunction

    task automatic rnd_core();
        core_addr = 18'($urandom);
        core_we   = 1'($urandom);
        core_di   = 8'($urandom);
        core_aux  = 1'($urandom);
    endtask

    task automatic step();
        logic [17:0] e_addr;
        logic        e_we, e_aux, e_ack;
        logic [7:0]  e_di;
        if (pz_auto) PHASE_ZERO = (cyc % 14 == 0);
        #1;
        if (!reset_n) model_reset();
        e_addr = core_addr; e_we = core_we; e_di = core_di; e_aux = core_aux; e_ack = 1'b0;
        if (m_clr_on) begin
            e_addr = 18'(m_clr_k % (int'(CT) + 1));
            e_aux  = (m_clr_k > int'(CT));
            e_we   = 1'b1;
            e_di   = 8'h00;
        end else if (cyc == m_acc) begin
            e_addr = m_addr; e_we = m_we; e_di = m_di; e_aux = m_aux;
        end else if (cyc == m_acc + 1) begin
            e_ack = 1'b1;
        end
        if (!reset_n) e_we = 1'b0;
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_we", 32'(ram_we), 32'(e_we));
        chk("ram_di", 32'(ram_di), 32'(e_di));
        chk("ram_aux", 32'(ram_aux), 32'(e_aux));
        chk("host_ack", 32'(host_ack), 32'(e_ack));
        chk("core_hold", 32'(core_hold), 32'(m_clr_on));
        chk("clear_busy", 32'(clear_busy), 32'(m_clr_on));
        if (e_ack && !m_we)
            chk("host_do", 32'(host_do), 32'(m_aux ? ram_do[15:8] : ram_do[7:0]));
        if (!reset_n)
            chk("host_do_rst", 32'(host_do), 32'h0);
        obs_ack = host_ack; obs_we = ram_we; obs_do = host_do; obs_addr = ram_addr;
        obs_di = ram_di; obs_aux = ram_aux; obs_busy = clear_busy; obs_cyc = cyc;
        @(posedge CLK_14M);
        if (reset_n) begin
            if (m_clr_on) begin
                m_clr_k++;
                if (m_clr_k == CLR_N) m_clr_on = 0;
            end else if (m_armed) begin
                if (m_slot == HS) begin
                    m_armed = 0;
                    m_acc   = cyc + 1;
                end
            end else if (cyc != m_acc && cyc != m_acc + 1 && host_req) begin
                m_armed = 1; m_we = host_we; m_aux = host_aux; m_addr = host_addr; m_di = host_di;
            end
            m_slot = (PHASE_ZERO && !m_pz) ? 0 : (m_slot + 1) % 14;
            m_pz   = PHASE_ZERO;
        end
        cyc++;
        #1;
    endtask

    // One host transaction latched in a given slot; checks edge latency from
    // the latch edge to ack, the write pulse and read data.
    task automatic host_txn(input string tag, input logic we, input logic [17:0] addr,
                            input logic aux, input logic [7:0] di, input int start_slot,
                            input int exp_lat, input logic [7:0] exp_do);
        int lc, ack_c, wes;
        bit got, synced;
        logic [17:0] w_addr;
        logic [7:0]  w_di, r_do;
        synced = 0;
        host_req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (model_idle() && m_slot == start_slot) begin
                synced = 1;
                break;
            end
            rnd_core(); core_we = 1'b0;
            step();
        end
        chk({tag, "_sync"}, 32'(synced), 32'h1);
        host_req = 1'b1; host_we = we; host_addr = addr; host_aux = aux; host_di = di;
        lc = cyc;
        rnd_core(); core_we = 1'b0;
        step();
        got = 0; wes = 0; ack_c = -1; w_addr = '0; w_di = '0; r_do = '0;
        for (int i = 0; i < 40; i++) begin
            rnd_core(); core_we = 1'b0;
            step();
            if (obs_we) begin
                wes++; w_addr = obs_addr; w_di = obs_di;
            end
            if (obs_ack) begin
                got = 1; ack_c = obs_cyc; r_do = obs_do;
                break;
            end
        end
        host_req = 1'b0;
        chk({tag, "_ack_seen"}, 32'(got), 32'h1);
        chk({tag, "_latency"}, 32'(ack_c - lc - 1), 32'(exp_lat));
        chk({tag, "_we_pulses"}, 32'(wes), 32'(we));
        if (we) begin
            chk({tag, "_wr_addr"}, 32'(w_addr), 32'(addr));
            chk({tag, "_wr_data"}, 32'(w_di), 32'(di));
        end else begin
            chk({tag, "_rd_data"}, 32'(r_do), 32'(exp_do));
        end
    endtask

    initial begin
        int n_ack, n_we_rst;
        reset_n = 1'b0; PHASE_ZERO = 1'b0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_aux = 1'b0; host_di = '0; ram_do = 16'hA5C3;
        rnd_core();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rnd_core();
            step();
        end
        reset_n = 1'b1;

`ifdef APPLE2_RAM_CLEAR_EN
        begin
            int nb, nm, na;
            bit served;
            nb = 0; nm = 0; na = 0; served = 0;
            host_req = 1'b1; host_we = 1'b1; host_addr = 18'h00123; host_aux = 1'b0; host_di = 8'h77;
            for (int i = 0; i < 100; i++) begin
                rnd_core();
                step();
                if (!obs_busy) break;
                nb++;
                if (obs_we && obs_di == 8'h00) begin
                    if (obs_aux) na++;
                    else nm++;
                end
            end
            chk("clear_cycles", 32'(nb), 32'(CLR_N));
            chk("clear_main_writes", 32'(nm), 32'(int'(CT) + 1));
            chk("clear_aux_writes", 32'(na), 32'(int'(CT) + 1));
            for (int i = 0; i < 40; i++) begin
                rnd_core();
                step();
                if (obs_ack) begin
                    served = 1;
                    break;
                end
            end
            host_req = 1'b0;
            chk("clear_req_served", 32'(served), 32'h1);
        end
`endif

        host_txn("wr_5a", 1'b1, 18'h00400, 1'b0, 8'h5A, 12, 2, 8'h00);
        host_txn("rd_aux", 1'b0, 18'h02000, 1'b1, 8'h00, 12, 2, 8'hA5);
        host_txn("rd_main", 1'b0, 18'h02000, 1'b0, 8'h00, 13, 15, 8'hC3);
        host_txn("rd_slot0", 1'b0, 18'h02000, 1'b1, 8'h00, 0, 14, 8'hA5);

        // Reset while ARMED discards the request
        for (int i = 0; i < 60 && !(model_idle() && m_slot == 0); i++) begin
            rnd_core();
            step();
        end
        host_req = 1'b1; host_we = 1'b1; host_addr = 18'h01111; host_di = 8'h3C;
        step();
        host_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rnd_core();
            step();
        end
        reset_n = 1'b0;
        n_we_rst = 0;
        for (int i = 0; i < 2; i++) begin
            rnd_core(); core_we = 1'b1;
            step();
            if (obs_we) n_we_rst++;
        end
        chk("rst_we_forced_low", 32'(n_we_rst), 32'h0);
        reset_n = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 20 + CLR_N; i++) begin
            rnd_core();
            step();
            if (obs_ack) n_ack++;
        end
        chk("rst_no_ack", 32'(n_ack), 32'h0);
        host_txn("after_rst", 1'b1, 18'h00401, 1'b1, 8'hE7, 12, 2, 8'h00);

        // Random traffic with irregular PHASE_ZERO and occasional resets
        pz_auto = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rnd_core();
            PHASE_ZERO = ($urandom_range(0, 13) == 0);
            host_req   = 1'($urandom);
            host_we    = 1'($urandom);
            host_addr  = 18'($urandom);
            host_aux   = 1'($urandom);
            host_di    = 8'($urandom);
            ram_do     = 16'($urandom);
            reset_n    = ($urandom_range(0, 249) != 0);
            step();
        end
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
